// File: rtl/operand_entry_sequencer.sv
// Operand entry sequencer: synchronises and debounces the enter and clear
// buttons, then steps through A entry, B/carry entry and a display hold,
// presenting registered operands and carry-in to the downstream adder.
module operand_entry_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:0]   switches,
  input  logic             key_n,
  input  logic             clr_n,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             carry_in,
  output logic             operands_valid,
  output logic             load_pulse,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    SHOW    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam int NBTN = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 is enter (key_n), index 1 is clear (clr_n).
  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync_1;
  logic [NBTN-1:0]  sync_2;
  logic [NBTN-1:0]  deb_level;
  logic [NBTN-1:0]  deb_level_d;
  logic [CNT_W-1:0] deb_cnt [NBTN];
  logic             key_evt;
  logic             clr_evt;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] operand_a_next;
  logic [WIDTH-1:0] operand_b_next;
  logic             carry_in_next;
  logic             operands_valid_next;
  logic             load_pulse_next;

  assign btn_raw = {clr_n, key_n};

  // Two-flop synchronisers; reset to the released level so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level   <= '1;
      deb_level_d <= '1;
      for (int i = 0; i < NBTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      deb_level_d <= deb_level;
      for (int i = 0; i < NBTN; i++) begin
        if (sync_2[i] == deb_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb_level[i] <= sync_2[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the cycle after the debounced level falls; releases produce nothing.
  assign key_evt = deb_level_d[0] & ~deb_level[0];
  assign clr_evt = deb_level_d[1] & ~deb_level[1];

  // State and output registers; all outputs are registered so the adder sees clean values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_A;
      operand_a      <= '0;
      operand_b      <= '0;
      carry_in       <= 1'b0;
      operands_valid <= 1'b0;
      load_pulse     <= 1'b0;
    end else begin
      state          <= state_next;
      operand_a      <= operand_a_next;
      operand_b      <= operand_b_next;
      carry_in       <= carry_in_next;
      operands_valid <= operands_valid_next;
      load_pulse     <= load_pulse_next;
    end
  end

  // Next-state logic: clear wins over enter, captures happen only on enter events.
  always_comb begin
    state_next      = state;
    operand_a_next  = operand_a;
    operand_b_next  = operand_b;
    carry_in_next   = carry_in;
    load_pulse_next = 1'b0;

    if (clr_evt) begin
      state_next     = WAIT_A;
      operand_a_next = '0;
      operand_b_next = '0;
      carry_in_next  = 1'b0;
    end else begin
      case (state)
        WAIT_A: begin
          if (key_evt) begin
            operand_a_next = switches[WIDTH-1:0];
            state_next     = WAIT_B;
          end
        end
        WAIT_B: begin
          if (key_evt) begin
            operand_b_next  = switches[WIDTH-1:0];
            carry_in_next   = switches[WIDTH];
            state_next      = SHOW;
            load_pulse_next = 1'b1;
          end
        end
        SHOW: begin
          if (key_evt) begin
            state_next = WAIT_A;
          end
        end
        default: begin
          state_next = WAIT_A;
        end
      endcase
    end

    operands_valid_next = (state_next == SHOW);
  end

  assign state_o = state;

endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Self-checking bench for operand_entry_sequencer: directed scenarios followed
// by random button activity, all compared against a behavioural model.
module tb_operand_entry_sequencer;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH:0]   switches;
  logic             key_n;
  logic             clr_n;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             carry_in;
  logic             operands_valid;
  logic             load_pulse;
  logic [1:0]       state_o;

  int total = 0;
  int bad   = 0;

  operand_entry_sequencer #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .switches(switches),
    .key_n(key_n),
    .clr_n(clr_n),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .carry_in(carry_in),
    .operands_valid(operands_valid),
    .load_pulse(load_pulse),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per button, a window of recent input samples; the accepted
  // level flips once the D samples seen after the 2-cycle synchroniser delay all
  // disagree with it. A fall becomes an event one edge later.
  bit       hist [2][DEB+1];
  bit       m_deb [2];
  bit       m_fell [2];
  int       m_state;
  int       m_a;
  int       m_b;
  int       m_c;
  bit       m_valid;
  bit       m_load;

  // Model update on every edge, reset asynchronously with the DUT.
  always @(posedge clk or negedge rst_n) begin
    bit kevt;
    bit cevt;
    bit diff;
    bit smp [2];
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k <= DEB; k++) hist[b][k] = 1'b1;
        m_deb[b]  = 1'b1;
        m_fell[b] = 1'b0;
      end
      m_state = 0; m_a = 0; m_b = 0; m_c = 0; m_valid = 0; m_load = 0;
    end else begin
      kevt = m_fell[0];
      cevt = m_fell[1];
      smp[0] = key_n;
      smp[1] = clr_n;
      for (int b = 0; b < 2; b++) begin
        diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (hist[b][k] == m_deb[b]) diff = 1'b0;
        m_fell[b] = diff && m_deb[b];
        if (diff) m_deb[b] = !m_deb[b];
        for (int k = 0; k < DEB; k++) hist[b][k] = hist[b][k+1];
        hist[b][DEB] = smp[b];
      end
      m_load = 1'b0;
      if (m_state == 3) begin
        m_state = 0;
      end
      if (cevt) begin
        m_state = 0; m_a = 0; m_b = 0; m_c = 0;
      end else if (kevt) begin
        if (m_state == 0) begin
          m_a = int'(switches[WIDTH-1:0]);
          m_state = 1;
        end else if (m_state == 1) begin
          m_b = int'(switches[WIDTH-1:0]);
          m_c = int'(switches[WIDTH]);
          m_state = 2;
          m_load = 1'b1;
        end else begin
          m_state = 0;
        end
      end
      m_valid = (m_state == 2);
    end
  end

  // Single directed comparison against a bench-computed constant.
  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_output();
    check_val("state_o", int'(state_o), m_state);
    check_val("operand_a", int'(operand_a), m_a);
    check_val("operand_b", int'(operand_b), m_b);
    check_val("carry_in", int'(carry_in), m_c);
    check_val("operands_valid", int'(operands_valid), int'(m_valid));
    check_val("load_pulse", int'(load_pulse), int'(m_load));
  endtask

  // One clock of stimulus: wait to the falling edge, then check outputs.
  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      check_output();
    end
  endtask

  task automatic press_release(input int hold, input int rel);
    key_n = 1'b0;
    apply_stimulus(hold);
    key_n = 1'b1;
    apply_stimulus(rel);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, " state_o"}, int'(state_o), 0);
    check_val({tag, " operand_a"}, int'(operand_a), 0);
    check_val({tag, " operand_b"}, int'(operand_b), 0);
    check_val({tag, " carry_in"}, int'(carry_in), 0);
    check_val({tag, " valid"}, int'(operands_valid), 0);
    check_val({tag, " load"}, int'(load_pulse), 0);
  endtask

  initial begin
    rst_n    = 1'b1;
    key_n    = 1'b0;
    clr_n    = 1'b1;
    switches = 5'b0_1001;

    // Reset with enter held low: no press from reset release, one press after 7 edges.
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    apply_stimulus(3);
    rst_n = 1'b1;
    apply_stimulus(6);
    check_val("held_key_before_evt", int'(state_o), 0);
    apply_stimulus(1);
    check_val("held_key_evt", int'(state_o), 1);
    check_val("held_key_capture", int'(operand_a), 9);
    apply_stimulus(13);
    check_val("held_key_single", int'(state_o), 1);
    key_n = 1'b1;
    apply_stimulus(10);

    // Clear back to the start.
    clr_n = 1'b0;
    apply_stimulus(10);
    clr_n = 1'b1;
    apply_stimulus(10);
    check_val("clear_state", int'(state_o), 0);
    check_val("clear_a", int'(operand_a), 0);

    // Bouncy press for A: short low pulses are rejected.
    switches = 5'b0_0011;
    for (int i = 0; i < 6; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      apply_stimulus(2);
    end
    check_val("bounce_no_capture", int'(state_o), 0);
    key_n = 1'b0;
    apply_stimulus(6);
    check_val("bounce_pre_evt", int'(state_o), 0);
    apply_stimulus(1);
    check_val("bounce_evt_state", int'(state_o), 1);
    check_val("bounce_evt_a", int'(operand_a), 3);
    apply_stimulus(5);
    key_n = 1'b1;
    apply_stimulus(10);

    // B and carry entry into SHOW.
    switches = 5'b1_0101;
    key_n = 1'b0;
    apply_stimulus(7);
    check_val("show_state", int'(state_o), 2);
    check_val("show_a", int'(operand_a), 3);
    check_val("show_b", int'(operand_b), 5);
    check_val("show_c", int'(carry_in), 1);
    check_val("show_valid", int'(operands_valid), 1);
    check_val("show_load", int'(load_pulse), 1);
    apply_stimulus(1);
    check_val("show_load_drop", int'(load_pulse), 0);
    key_n = 1'b1;
    apply_stimulus(10);

    // Leave SHOW: operands retained.
    switches = 5'b1_1111;
    press_release(8, 10);
    check_val("exit_state", int'(state_o), 0);
    check_val("exit_valid", int'(operands_valid), 0);
    check_val("exit_a", int'(operand_a), 3);
    check_val("exit_b", int'(operand_b), 5);

    // Enter A, then enter and clear together in WAIT_B: clear wins.
    switches = 5'b0_0110;
    press_release(8, 10);
    check_val("pre_simul_state", int'(state_o), 1);
    key_n = 1'b0;
    clr_n = 1'b0;
    apply_stimulus(7);
    check_zero_outputs("simul");
    apply_stimulus(1);
    check_val("simul_no_load", int'(load_pulse), 0);
    key_n = 1'b1;
    clr_n = 1'b1;
    apply_stimulus(10);

    // Async reset mid-entry in WAIT_B.
    switches = 5'b0_1010;
    press_release(8, 10);
    check_val("pre_rst_state", int'(state_o), 1);
    check_val("pre_rst_a", int'(operand_a), 10);
    rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    apply_stimulus(1);
    rst_n = 1'b1;
    apply_stimulus(3);
    check_val("post_rst_state", int'(state_o), 0);
    switches = 5'b0_0111;
    press_release(8, 10);
    check_val("fresh_a_state", int'(state_o), 1);
    check_val("fresh_a", int'(operand_a), 7);

    // Random button activity and switch changes against the model.
    for (int i = 0; i < 150; i++) begin
      switches = 5'($urandom);
      key_n    = 1'($urandom_range(0, 1));
      clr_n    = ($urandom_range(0, 7) != 0);
      apply_stimulus($urandom_range(1, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
